// File: rtl/fetch_imm_unit.sv
// Fetch stage of the MIPS datapath: PC, req/ack instruction fetch, instruction register and branch/jump targets.
// Optional macro ADDR_ERR_EN adds addrErr_out and a halt state on a misaligned next PC.
module fetch_imm_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
`ifdef ADDR_ERR_EN
    output logic        addrErr_out,
`endif
    input  logic        stall_in,
    input  logic        branchTaken_in,
    input  logic [31:0] immExt_in,
    input  logic        jump_in,
    input  logic [25:0] jumpIdx_in,
    input  logic        jr_in,
    input  logic [31:0] jrTarget_in,
    output logic        imemReq_out,
    output logic [31:0] imemAddr_out,
    input  logic        imemAck_in,
    input  logic [31:0] imemData_in,
    output logic [31:0] pc_out,
    output logic [31:0] pcPlus4_out,
    output logic [31:0] instr_out,
    output logic        instrValid_out,
    output logic [15:0] imm16_out,
    output logic        extendCntrl_out
);

`ifdef ADDR_ERR_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcPlus4_q, pcPlus4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_raw;
    logic [31:0] next_pc;
`ifdef ADDR_ERR_EN
    logic        addrErr_q, addrErr_d;
`endif

    always_comb begin
        if (jr_in) begin
            next_raw = jrTarget_in;
        end else if (jump_in) begin
            next_raw = {pcPlus4_q[31:28], jumpIdx_in, 2'b00};
        end else if (branchTaken_in) begin
            next_raw = pcPlus4_q + (immExt_in << 2);
        end else begin
            next_raw = pcPlus4_q;
        end
    end

`ifdef ADDR_ERR_EN
    assign next_pc = next_raw;
`else
    // Without the error path a misaligned target is silently word-aligned.
    assign next_pc = next_raw & 32'hFFFF_FFFC;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pcPlus4_d = pcPlus4_q;
        instr_d   = instr_q;
`ifdef ADDR_ERR_EN
        addrErr_d = addrErr_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imemAck_in) begin
                    instr_d = imemData_in;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall_in) begin
`ifdef ADDR_ERR_EN
                    if (next_pc[1:0] != 2'b00) begin
                        addrErr_d = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        pc_d      = next_pc;
                        pcPlus4_d = next_pc + 32'd4;
                        state_d   = S_FETCH;
                    end
`else
                    pc_d      = next_pc;
                    pcPlus4_d = next_pc + 32'd4;
                    state_d   = S_FETCH;
`endif
                end
            end
`ifdef ADDR_ERR_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            pcPlus4_q <= RESET_PC + 32'd4;
            instr_q   <= 32'h0;
`ifdef ADDR_ERR_EN
            addrErr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pcPlus4_q <= pcPlus4_d;
            instr_q   <= instr_d;
`ifdef ADDR_ERR_EN
            addrErr_q <= addrErr_d;
`endif
        end
    end

    // Request and valid decode straight from state so reset drops them at once.
    assign imemReq_out    = (state_q == S_FETCH);
    assign instrValid_out = (state_q == S_VALID);
    assign imemAddr_out   = pc_q;
    assign pc_out         = pc_q;
    assign pcPlus4_out    = pcPlus4_q;
    assign instr_out      = instr_q;
    assign imm16_out      = instr_q[15:0];
`ifdef ADDR_ERR_EN
    assign addrErr_out    = addrErr_q;
`endif

    always_comb begin
        case (instr_q[31:26])
            6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B:
                extendCntrl_out = 1'b1;
            default:
                extendCntrl_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fetch_imm_unit.sv
// Self-checking bench for fetch_imm_unit: directed scenarios plus randomized fetch/redirect traffic
// checked against a PC/extend reference model.
module tb_fetch_imm_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_in = 1'b0;
    logic        branchTaken_in = 1'b0;
    logic [31:0] immExt_in = 32'h0;
    logic        jump_in = 1'b0;
    logic [25:0] jumpIdx_in = 26'h0;
    logic        jr_in = 1'b0;
    logic [31:0] jrTarget_in = 32'h0;
    logic        imemReq_out;
    logic [31:0] imemAddr_out;
    logic        imemAck_in = 1'b0;
    logic [31:0] imemData_in = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] pcPlus4_out;
    logic [31:0] instr_out;
    logic        instrValid_out;
    logic [15:0] imm16_out;
    logic        extendCntrl_out;
`ifdef ADDR_ERR_EN
    logic        addrErr_out;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_pc;
    logic [31:0] last_word;

    fetch_imm_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
`ifdef ADDR_ERR_EN
        .addrErr_out(addrErr_out),
`endif
        .stall_in(stall_in), .branchTaken_in(branchTaken_in), .immExt_in(immExt_in),
        .jump_in(jump_in), .jumpIdx_in(jumpIdx_in), .jr_in(jr_in), .jrTarget_in(jrTarget_in),
        .imemReq_out(imemReq_out), .imemAddr_out(imemAddr_out),
        .imemAck_in(imemAck_in), .imemData_in(imemData_in),
        .pc_out(pc_out), .pcPlus4_out(pcPlus4_out), .instr_out(instr_out),
        .instrValid_out(instrValid_out), .imm16_out(imm16_out), .extendCntrl_out(extendCntrl_out)
    );

    always #5 clk = ~clk;

    function automatic logic ref_ext(input logic [5:0] op);
        return op inside {6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                          6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br, input logic jmp,
                                             input logic jr, input logic [31:0] imm,
                                             input logic [25:0] idx, input logic [31:0] jt);
        logic [31:0] p4, t;
        p4 = pc + 32'd4;
        if (jr) t = jt;
        else if (jmp) t = {p4[31:28], idx, 2'b00};
        else if (br) t = p4 + imm * 32'd4;
        else t = p4;
`ifndef ADDR_ERR_EN
        t = t & 32'hFFFF_FFFC;
`endif
        return t;
    endfunction

    // Wait for a request, hold ack off for 'delay' cycles, then return 'word'.
    task automatic do_fetch(input int delay, input logic [31:0] word);
        int w;
        w = 0;
        while (imemReq_out !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (imemReq_out !== 1'b1) begin
            errors++;
            $display("FAIL fetch_req_timeout: req=%b required 1", imemReq_out);
            return;
        end
        checks++;
        if (imemAddr_out !== exp_pc) begin
            errors++;
            $display("FAIL fetch_addr: got %h required %h", imemAddr_out, exp_pc);
        end
        for (int k = 0; k < delay; k++) begin
            imemAck_in = 1'b0;
            jr_in = 1'b1;
            jrTarget_in = $urandom & 32'hFFFF_FFFC;
            @(negedge clk);
            checks++;
            if (imemReq_out !== 1'b1 || imemAddr_out !== exp_pc || instrValid_out !== 1'b0) begin
                errors++;
                $display("FAIL fetch_hold: req=%b addr=%h vld=%b required 1 %h 0",
                         imemReq_out, imemAddr_out, instrValid_out, exp_pc);
            end
        end
        jr_in = 1'b0;
        imemAck_in = 1'b1;
        imemData_in = word;
        @(negedge clk);
        imemAck_in = 1'b0;
        imemData_in = $urandom;
        last_word = word;
        checks++;
        if (instrValid_out !== 1'b1 || imemReq_out !== 1'b0) begin
            errors++;
            $display("FAIL valid_state: vld=%b req=%b required 1 0", instrValid_out, imemReq_out);
        end
        checks++;
        if (instr_out !== word || imm16_out !== word[15:0]) begin
            errors++;
            $display("FAIL instr: got %h/%h required %h", instr_out, imm16_out, word);
        end
        checks++;
        if (extendCntrl_out !== ref_ext(word[31:26])) begin
            errors++;
            $display("FAIL extend: got %b required %b op=%h", extendCntrl_out,
                     ref_ext(word[31:26]), word[31:26]);
        end
        checks++;
        if (pc_out !== exp_pc || pcPlus4_out !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL pc: got %h/%h required %h/%h", pc_out, pcPlus4_out, exp_pc, exp_pc + 32'd4);
        end
    endtask

    // Stall for n cycles with decoy redirects, then release with the real redirect inputs.
    task automatic advance(input int n, input logic br, input logic jmp, input logic jr,
                           input logic [31:0] imm, input logic [25:0] idx, input logic [31:0] jt);
        for (int k = 0; k < n; k++) begin
            stall_in = 1'b1;
            jr_in = 1'b1;
            jrTarget_in = $urandom & 32'hFFFF_FFFC;
            jump_in = 1'b1;
            jumpIdx_in = 26'($urandom);
            @(negedge clk);
            checks++;
            if (pc_out !== exp_pc || instr_out !== last_word || instrValid_out !== 1'b1
                || imemReq_out !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: pc=%h instr=%h vld=%b req=%b required %h %h 1 0",
                         pc_out, instr_out, instrValid_out, imemReq_out, exp_pc, last_word);
            end
        end
        stall_in = 1'b0;
        branchTaken_in = br;
        jump_in = jmp;
        jr_in = jr;
        immExt_in = imm;
        jumpIdx_in = idx;
        jrTarget_in = jt;
        @(negedge clk);
        exp_pc = ref_next(exp_pc, br, jmp, jr, imm, idx, jt);
        branchTaken_in = 1'b0;
        jump_in = 1'b0;
        jr_in = 1'b0;
        checks++;
        if (instrValid_out !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: vld=%b required 0", instrValid_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pc_out !== RPC || pcPlus4_out !== RPC + 32'd4 || instr_out !== 32'h0
            || instrValid_out !== 1'b0 || imemReq_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h p4=%h instr=%h vld=%b req=%b", pc_out, pcPlus4_out,
                     instr_out, instrValid_out, imemReq_out);
        end
        reset = 1'b0;
        exp_pc = RPC;
    endtask

    task automatic test_sequential();
        do_fetch(0, 32'h2008_FFFF);
        advance(0, 0, 0, 0, 0, 0, 0);
        do_fetch(0, 32'h3508_FFFF);
        advance(0, 0, 0, 0, 0, 0, 0);
        do_fetch(0, 32'h0000_0020);
        advance(0, 0, 0, 0, 0, 0, 0);
        do_fetch(0, 32'h8C08_0004);
        advance(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_branch();
        do_fetch(0, 32'h1000_FFFE);
        advance(0, 1, 0, 0, 32'hFFFF_FFFE, 0, 0);
        do_fetch(0, 32'h3C08_1234);
        advance(0, 0, 0, 0, 0, 0, 0);
        do_fetch(1, 32'h1400_0003);
        advance(0, 1, 0, 0, 32'h0000_0003, 0, 0);
        do_fetch(0, 32'h0000_0000);
    endtask

    task automatic test_priority();
        advance(0, 1, 1, 1, 32'h0000_0010, 26'h3FF_FFFF, 32'h0040_1000);
        do_fetch(0, 32'h0800_0040);
        advance(0, 0, 0, 1, 0, 0, 32'h0040_0000);
        do_fetch(0, 32'h0810_0040);
        advance(0, 0, 1, 0, 0, 26'h010_0040, 0);
        do_fetch(0, 32'h2402_0001);
    endtask

    task automatic test_stall_delay();
        advance(3, 1, 0, 0, 32'h0000_0004, 0, 0);
        do_fetch(5, 32'h2129_8000);
        advance(2, 0, 0, 0, 0, 0, 0);
        do_fetch(3, 32'h3129_8000);
    endtask

    task automatic test_wrap();
        advance(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        do_fetch(0, 32'hAC01_0000);
        advance(0, 0, 0, 0, 0, 0, 0);
        do_fetch(0, 32'h1C00_FFFE);
        advance(0, 1, 0, 0, 32'hFFFF_FFFE, 0, 0);
        do_fetch(0, 32'h3800_0001);
    endtask

    task automatic test_reset_midfetch();
        advance(0, 0, 0, 1, 0, 0, 32'h0050_0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (imemReq_out !== 1'b0 || pc_out !== RPC || instrValid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_midfetch: req=%b pc=%h vld=%b required 0 %h 0",
                     imemReq_out, pc_out, instrValid_out, RPC);
        end
        imemAck_in = 1'b1;
        imemData_in = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        checks++;
        if (instr_out !== 32'h0 || imemReq_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack_ignored: instr=%h req=%b required 0 0", instr_out, imemReq_out);
        end
        imemAck_in = 1'b0;
        reset = 1'b0;
        exp_pc = RPC;
        do_fetch(0, 32'h2010_0001);
    endtask

    task automatic test_random();
        logic br, jmp, jr;
        logic [31:0] jt;
        for (int i = 0; i < 25; i++) begin
            advance($urandom_range(0, 2), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom, 26'($urandom),
                    $urandom & 32'hFFFF_FFFC);
            do_fetch($urandom_range(0, 3), $urandom);
        end
        br = 1'b0; jmp = 1'b0; jr = 1'b0; jt = 32'h0;
    endtask

    task automatic test_addr_align();
        advance(0, 0, 0, 1, 0, 0, 32'h0040_0000);
        do_fetch(0, 32'h0000_0008);
`ifdef ADDR_ERR_EN
        stall_in = 1'b0;
        jr_in = 1'b1;
        jrTarget_in = 32'h0040_0002;
        @(negedge clk);
        jr_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (addrErr_out !== 1'b1 || imemReq_out !== 1'b0 || instrValid_out !== 1'b0
                || pc_out !== exp_pc) begin
                errors++;
                $display("FAIL addr_err_halt: err=%b req=%b vld=%b pc=%h required 1 0 0 %h",
                         addrErr_out, imemReq_out, instrValid_out, pc_out, exp_pc);
            end
            @(negedge clk);
        end
`else
        advance(0, 0, 0, 1, 0, 0, 32'h0040_0002);
        do_fetch(0, 32'h2008_0001);
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_stall_delay();
        test_wrap();
        test_reset_midfetch();
        test_random();
        test_addr_align();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
